adder_ctrl: RTL
===============

# adder_ctrl

Sequencing controller for the 8-bit accumulate datapath (A counter, Sum accumulator, output register, A<11 comparator). On a start request it clears A and Sum, iterates the accumulate step while the datapath reports the loop condition, latches the sum into the output register, then holds `done` until acknowledged. An iteration counter with a timeout guards against a datapath that never ends the loop.

## Interface
- `CNT_W`, 8: width of the iteration counter.
- `MAX_ITER`, 255: iteration limit. If reached while `alt10` is still 1, the controller enters ERROR. Range 1..2^CNT_W-1.

- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: run request, sampled only in IDLE.
- `ack` in 1: consumer acknowledge of DONE or ERROR.
- `alt10` in 1: loop condition from the datapath comparator (A < 11).
- `asrc_mux_sel` out 1: 0 selects zero into A/Sum, 1 selects the adder results.
- `a_load` out 1: load enable for the A and Sum registers.
- `out_load` out 1: load enable for the output register.
- `busy` out 1: high in CLEAR, LOOP and LATCH.
- `done` out 1: result valid in the output register.
- `error` out 1: timeout flag.
- `iter_cnt` out CNT_W: number of accumulate loads issued in the current or last run.

## Operation
- States: IDLE, CLEAR, LOOP, LATCH, DONE, ERROR. Binary encoding; the state register is the only source for Moore outputs.
- IDLE: all control outputs 0. `start=1` → CLEAR. Otherwise stay.
- CLEAR: `asrc_mux_sel=0`, `a_load=1` for exactly one cycle. `iter_cnt` is cleared to 0. Next state is LOOP.
- LOOP: `asrc_mux_sel=1`.
  - `alt10=1` and `iter_cnt<MAX_ITER`: `a_load=1` (Mealy on `alt10`), `iter_cnt` increments, stay in LOOP.
  - `alt10=1` and `iter_cnt==MAX_ITER`: `a_load=0`, go to ERROR.
  - `alt10=0`: `a_load=0`, go to LATCH.
- LATCH: `out_load=1` for one cycle, `asrc_mux_sel=1`, `a_load=0`. Next state is DONE.
- DONE: `done=1`. `ack=1` → IDLE. `start` is ignored.
- ERROR: `error=1`, `out_load` is never issued. `ack=1` → IDLE.
- `iter_cnt` holds its value in LATCH, DONE, ERROR and IDLE, so it can be read back after a run. It saturates at `MAX_ITER` and never wraps.
- `start` is ignored outside IDLE; a held `start` does not queue a second run.
- If `ack` and `start` are both high in DONE, only `ack` acts. The next run needs `start` in IDLE.
- Reset, including mid-run, forces IDLE immediately. All outputs go to 0 and `iter_cnt` goes to 0.

## Timing
- Reset values: `asrc_mux_sel=0`, `a_load=0`, `out_load=0`, `busy=0`, `done=0`, `error=0`, `iter_cnt=0`.
- `start` sampled high at edge k gives CLEAR during cycle k..k+1 and LOOP from edge k+1.
- N cycles of `alt10=1` produce N `a_load` pulses, followed by LATCH for one cycle. `done` rises 3+N edges after the edge that sampled `start`.
- Standard datapath run (A counts 0→11): N=11, `done` rises 14 edges after `start`, `iter_cnt=11`.
- `alt10` is used combinationally for `a_load` in LOOP. The datapath comparator output must settle within the same cycle.
- `busy`, `done` and `error` are pure state decodes with no same-cycle dependence on inputs.

## Configuration
- `ADDER_CTRL_AUTO_ACK_EN` defined: DONE and ERROR each last exactly one cycle, then the controller returns to IDLE. `done` and `error` become single-cycle pulses and `ack` is ignored.
- `ADDER_CTRL_AUTO_ACK_EN` undefined (default): DONE and ERROR hold until `ack=1`.

## Test plan
- **Reset:** hold `reset_n=0`, then release → all outputs 0, state IDLE. Pulse `start` → `a_load=1`, `asrc_mux_sel=0` on the next cycle.
- **Nominal run:** behavioural datapath model counting A 0→11 → exactly 11 `a_load` pulses with `asrc_mux_sel=1`, one `out_load`, `done` at edge 14, `iter_cnt=11`, model output register = 66. `ack` → IDLE.
- **Timeout:** `MAX_ITER=5`, `alt10` tied 1 → 5 `a_load` pulses in LOOP, `error=1`, no `out_load`, `iter_cnt=5`. `ack` clears `error`.
- **Start ignored while busy:** `start` held high through a whole run → exactly one run. No second CLEAR until IDLE is reached and `start` is sampled again.
- **Reset mid-run:** drop `reset_n` in LOOP at `iter_cnt=4` → outputs 0 asynchronously (before the next edge), `iter_cnt=0`. A new `start` gives a full 11-iteration run.
- **`ADDER_CTRL_AUTO_ACK_EN` defined:** nominal run → `done` high for exactly 1 cycle, IDLE on the following edge, with `ack` held 0.

Source files
------------

// File: rtl/adder_ctrl.sv
// Sequencing controller for the 8-bit accumulate datapath (A counter, Sum, output register, A<11 compare).
// Latency: start sampled at edge k -> CLEAR k..k+1, LOOP from k+1, done rises at edge k+3+N for N loop loads.
// Backpressure: DONE/ERROR hold until ack (start ignored outside IDLE); with ADDER_CTRL_AUTO_ACK_EN they last one cycle.
//
// Optional feature macro: ADDER_CTRL_AUTO_ACK_EN
//   defined   : DONE and ERROR each last exactly one cycle, then IDLE; ack is ignored.
//   undefined : DONE and ERROR hold until ack=1 (default build).
//
// Ports:
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset; forces IDLE, all outputs 0, iter_cnt 0
//   start         run request, only sampled in IDLE
//   ack           consumer acknowledge of DONE / ERROR
//   alt10         datapath loop condition (A < 11); used combinationally in LOOP
//   asrc_mux_sel  0: zero into A/Sum, 1: adder results into A/Sum
//   a_load        load enable for A and Sum
//   out_load      load enable for the output register
//   busy          high in CLEAR, LOOP, LATCH
//   done          result valid in the output register
//   error         iteration limit reached with the loop still running
//   iter_cnt      accumulate loads issued in the current or last run (saturates at MAX_ITER)

module adder_ctrl #(
    parameter int CNT_W    = 8,
    parameter int MAX_ITER = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             ack,
    input  logic             alt10,
    output logic             asrc_mux_sel,
    output logic             a_load,
    output logic             out_load,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] iter_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOOP  = 3'd2,
        S_LATCH = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

    state_t state_q;
    state_t state_d;

    // Counter control produced by the next-state logic.
    logic cnt_clr;
    logic cnt_inc;

    // Headroom left before the iteration limit; when false the loop is timed out.
    logic iter_room;
    assign iter_room = (iter_cnt < MAX_CNT);

    // Release path out of DONE / ERROR.
`ifdef ADDER_CTRL_AUTO_ACK_EN
    logic leave_hold;
    logic unused_ack;
    assign leave_hold = 1'b1;
    assign unused_ack = ack;
`else
    logic leave_hold;
    assign leave_hold = ack;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Iteration counter: cleared in CLEAR, bumped once per accumulate load,
    // held everywhere else so the last run's count stays readable.
    // Increment is only issued below the limit, so it can never wrap.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            iter_cnt <= '0;
        end else if (cnt_clr) begin
            iter_cnt <= '0;
        end else if (cnt_inc) begin
            iter_cnt <= iter_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs. busy/done/error depend on state only;
    // a_load in LOOP is the single Mealy output (follows alt10).
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        asrc_mux_sel = 1'b0;
        a_load       = 1'b0;
        out_load     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                end
            end

            S_CLEAR: begin
                busy    = 1'b1;
                a_load  = 1'b1;
                cnt_clr = 1'b1;
                state_d = S_LOOP;
            end

            S_LOOP: begin
                busy         = 1'b1;
                asrc_mux_sel = 1'b1;
                if (alt10) begin
                    if (iter_room) begin
                        a_load  = 1'b1;
                        cnt_inc = 1'b1;
                    end else begin
                        // Datapath still wants to loop but the budget is spent.
                        state_d = S_ERROR;
                    end
                end else begin
                    state_d = S_LATCH;
                end
            end

            S_LATCH: begin
                busy         = 1'b1;
                asrc_mux_sel = 1'b1;
                out_load     = 1'b1;
                state_d      = S_DONE;
            end

            S_DONE: begin
                done = 1'b1;
                // start is deliberately not looked at here: ack alone
                // returns to IDLE and a new run needs start in IDLE.
                if (leave_hold) begin
                    state_d = S_IDLE;
                end
            end

            S_ERROR: begin
                error = 1'b1;
                if (leave_hold) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
